tile_seq_ctrl: RTL and testbench

- Command-driven sequencer for one single-PE systolic tile (8-bit a/b operands, 16-bit d/c, one propagate control bit).
- Accepts PRELOAD / COMPUTE / FLUSH commands and streams paired a/b operands into the tile.
- Inserts zero bubbles when operands stall and waits out the PE pipeline latency.
- Captures the tile's c output and returns it on a valid/ready result port. Sits between the operand buffers and the tile instance.

---
 rtl/tile_ctrl_pkg.sv | 21 ++
 rtl/tile_lat_counter.sv | 33 +++
 rtl/tile_seq_ctrl.sv | 173 +++++++++++++++++
 tb/tb_tile_seq_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_ctrl_pkg.sv
// Shared definitions for the tile sequencer: opcodes, FSM states and tile operand widths.
package tile_ctrl_pkg;

  localparam int unsigned A_W = 8;
  localparam int unsigned B_W = 8;
  localparam int unsigned C_W = 16;

  localparam logic [1:0] OP_PRELOAD = 2'd0;
  localparam logic [1:0] OP_COMPUTE = 2'd1;
  localparam logic [1:0] OP_FLUSH   = 2'd2;

  typedef enum logic [2:0] {
    StIdle,
    StPreload,
    StStream,
    StDrain,
    StFlushWait,
    StResult
  } state_e;

endpackage

// File: rtl/tile_lat_counter.sv
// Loadable down-counter that saturates at zero; waits out the PE pipeline latency.
module tile_lat_counter #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             done_o,
  output logic             last_o
);

  logic [Width-1:0] count_q;

  // Load takes priority over decrement; never wraps below zero.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - Width'(1);
    end
  end

  // done: already at zero; last: the next decrement reaches zero (or already there).
  always_comb begin
    done_o = (count_q == '0);
    last_o = (count_q <= Width'(1));
  end

endmodule

// File: rtl/tile_seq_ctrl.sv
// Command sequencer for a single-PE systolic tile: preload, operand streaming, flush/result.
module tile_seq_ctrl
  import tile_ctrl_pkg::*;
#(
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned PE_LAT = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [C_W-1:0]   cmd_bias,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [A_W-1:0]   a_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [B_W-1:0]   b_data,
  output logic [A_W-1:0]   tile_in_a,
  output logic [B_W-1:0]   tile_in_b,
  output logic [C_W-1:0]   tile_in_d,
  output logic             tile_in_propagate,
  input  logic [C_W-1:0]   tile_out_c,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [C_W-1:0]   res_data,
  output logic             busy,
  output logic             err
);

  localparam int unsigned    LatW    = (PE_LAT > 0) ? $clog2(PE_LAT + 1) : 1;
  localparam logic [LatW-1:0] LatLoad = LatW'(PE_LAT);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] beat_q, beat_d;
  logic             prop_q, prop_d;
  logic [A_W-1:0]   a_q, a_d;
  logic [B_W-1:0]   b_q, b_d;
  logic [C_W-1:0]   d_q, d_d;
  logic             res_valid_q, res_valid_d;
  logic [C_W-1:0]   res_data_q, res_data_d;
  logic             err_q, err_d;
  logic             xfer;
  logic             lat_load, lat_dec, lat_done, lat_last;

  tile_lat_counter #(
    .Width(LatW)
  ) u_lat_counter (
    .clk_i     (clock),
    .rst_ni    (reset_n),
    .load_i    (lat_load),
    .load_val_i(LatLoad),
    .dec_i     (lat_dec),
    .done_o    (lat_done),
    .last_o    (lat_last)
  );

  // Both operand streams move together or not at all.
  assign xfer = (state_q == StStream) && a_valid && b_valid;

  // Next-state and registered-output next values; operands default to zero each cycle.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    prop_d      = prop_q;
    a_d         = '0;
    b_d         = '0;
    d_d         = '0;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    err_d       = err_q;
    lat_load    = 1'b0;
    lat_dec     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_PRELOAD: begin
              d_d     = cmd_bias;
              prop_d  = ~prop_q;
              state_d = StPreload;
            end
            OP_COMPUTE: begin
              if (cmd_len != '0) begin
                beat_d  = cmd_len;
                state_d = StStream;
              end
            end
            OP_FLUSH: begin
              prop_d   = ~prop_q;
              lat_load = 1'b1;
              state_d  = StFlushWait;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      StPreload: state_d = StIdle;
      StStream: begin
        if (xfer) begin
          a_d    = a_data;
          b_d    = b_data;
          beat_d = beat_q - LEN_W'(1);
          if (beat_q == LEN_W'(1)) begin
            lat_load = 1'b1;
            state_d  = StDrain;
          end
        end
      end
      StDrain: begin
        lat_dec = 1'b1;
        if (lat_last) state_d = StIdle;
      end
      StFlushWait: begin
        if (lat_done) begin
          res_data_d  = tile_out_c;
          res_valid_d = 1'b1;
          state_d     = StResult;
        end else begin
          lat_dec = 1'b1;
        end
      end
      StResult: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      beat_q      <= '0;
      prop_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      d_q         <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      prop_q      <= prop_d;
      a_q         <= a_d;
      b_q         <= b_d;
      d_q         <= d_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      err_q       <= err_d;
    end
  end

  assign cmd_ready         = (state_q == StIdle);
  assign busy              = (state_q != StIdle);
  assign a_ready           = xfer;
  assign b_ready           = xfer;
  assign tile_in_a         = a_q;
  assign tile_in_b         = b_q;
  assign tile_in_d         = d_q;
  assign tile_in_propagate = prop_q;
  assign res_valid         = res_valid_q;
  assign res_data          = res_data_q;
  assign err               = err_q;

endmodule

// File: tb/tb_tile_seq_ctrl.sv
// Self-checking bench for tile_seq_ctrl: directed scenarios plus randomized traffic vs a model.
module tb_tile_seq_ctrl;

  localparam int unsigned LEN_W  = 8;
  localparam int unsigned PE_LAT = 1;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'd0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic [15:0]      cmd_bias = '0;
  logic             a_valid = 1'b0, a_ready;
  logic [7:0]       a_data = '0;
  logic             b_valid = 1'b0, b_ready;
  logic [7:0]       b_data = '0;
  logic [7:0]       tile_in_a, tile_in_b;
  logic [15:0]      tile_in_d;
  logic             tile_in_propagate;
  logic [15:0]      tile_out_c = '0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [15:0]      res_data;
  logic             busy, err;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int drv_mode = 0;

  // Observation counters
  int cyc = 0, xfers = 0, first_x = -1, last_x = -1, ready_pulses = 0, results = 0, mac_sum = 0;

  // Model state: remaining work per activity, plus expected registered outputs
  int         m_pre = 0, m_beats = 0, m_drain = 0, m_flush = 0;
  bit         m_res = 1'b0;
  logic [7:0] e_a = '0, e_b = '0;
  logic [15:0] e_d = '0, e_res_data = '0;
  bit         e_prop = 1'b0, e_res_valid = 1'b0, e_err = 1'b0;

  tile_seq_ctrl #(
    .LEN_W (LEN_W),
    .PE_LAT(PE_LAT)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_op           (cmd_op),
    .cmd_len          (cmd_len),
    .cmd_bias         (cmd_bias),
    .a_valid          (a_valid),
    .a_ready          (a_ready),
    .a_data           (a_data),
    .b_valid          (b_valid),
    .b_ready          (b_ready),
    .b_data           (b_data),
    .tile_in_a        (tile_in_a),
    .tile_in_b        (tile_in_b),
    .tile_in_d        (tile_in_d),
    .tile_in_propagate(tile_in_propagate),
    .tile_out_c       (tile_out_c),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_data         (res_data),
    .busy             (busy),
    .err              (err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic bit m_idle();
    return (m_pre == 0) && (m_beats == 0) && (m_drain == 0) && (m_flush == 0) && !m_res;
  endfunction

  // Reference model: advances on each rising edge from the inputs presented before it.
  always @(posedge clock) begin
    if (!reset_n) begin
      m_pre = 0; m_beats = 0; m_drain = 0; m_flush = 0; m_res = 1'b0;
      e_a = '0; e_b = '0; e_d = '0; e_prop = 1'b0;
      e_res_valid = 1'b0; e_res_data = '0; e_err = 1'b0;
    end else begin
      bit idle;
      idle = m_idle();
      e_a = '0; e_b = '0; e_d = '0;
      if (idle) begin
        if (cmd_valid) begin
          case (cmd_op)
            2'd0: begin e_d = cmd_bias; e_prop = !e_prop; m_pre = 1; end
            2'd1: m_beats = int'(cmd_len);
            2'd2: begin e_prop = !e_prop; m_flush = PE_LAT + 1; end
            default: e_err = 1'b1;
          endcase
        end
      end else if (m_pre > 0) begin
        m_pre = 0;
      end else if (m_beats > 0) begin
        if (a_valid && b_valid) begin
          e_a = a_data; e_b = b_data;
          m_beats--;
          if (m_beats == 0) m_drain = (PE_LAT > 0) ? PE_LAT : 1;
        end
      end else if (m_drain > 0) begin
        m_drain--;
      end else if (m_flush > 0) begin
        m_flush--;
        if (m_flush == 0) begin
          e_res_valid = 1'b1; e_res_data = tile_out_c; m_res = 1'b1;
        end
      end else if (m_res && res_ready) begin
        m_res = 1'b0; e_res_valid = 1'b0;
      end
    end
  end

  // Compare DUT against the model on every falling edge, and gather observations.
  always @(negedge clock) begin
    if (chk_en) begin
      bit idle;
      bit st;
      idle = m_idle();
      st   = (m_beats > 0);
      chk("cmd_ready", cmd_ready, idle);
      chk("busy", busy, !idle);
      chk("a_ready", a_ready, st && a_valid && b_valid);
      chk("b_ready", b_ready, st && a_valid && b_valid);
      chk("tile_in_a", tile_in_a, e_a);
      chk("tile_in_b", tile_in_b, e_b);
      chk("tile_in_d", tile_in_d, e_d);
      chk("tile_in_propagate", tile_in_propagate, e_prop);
      chk("res_valid", res_valid, e_res_valid);
      chk("res_data", res_data, e_res_data);
      chk("err", err, e_err);
      cyc++;
      if (a_ready && a_valid && b_valid) begin
        xfers++;
        if (first_x < 0) first_x = cyc;
        last_x = cyc;
      end
      if (a_ready || b_ready) ready_pulses++;
      mac_sum += int'(tile_in_a) * int'(tile_in_b);
      if (res_valid && res_ready) results++;
    end
  end

  // Background operand/command driver for continuous and random phases.
  always @(posedge clock) begin
    #1;
    if (drv_mode == 1) begin
      a_valid = 1'b1; b_valid = 1'b1;
      a_data = 8'($urandom); b_data = 8'($urandom);
    end else if (drv_mode == 2) begin
      cmd_valid  = ($urandom_range(0, 2) == 0);
      cmd_op     = 2'($urandom_range(0, 3));
      cmd_len    = LEN_W'($urandom_range(0, 6));
      cmd_bias   = 16'($urandom);
      a_valid    = ($urandom_range(0, 3) != 0);
      b_valid    = ($urandom_range(0, 3) != 0);
      a_data     = 8'($urandom);
      b_data     = 8'($urandom);
      res_ready  = ($urandom_range(0, 1) == 1);
      tile_out_c = 16'($urandom);
      reset_n    = ($urandom_range(0, 299) != 0);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op, input int len, input logic [15:0] bias);
    int n;
    cmd_valid = 1'b1; cmd_op = op; cmd_len = LEN_W'(len); cmd_bias = bias;
    for (n = 0; n < 200; n++) begin
      @(negedge clock);
      if (cmd_ready) break;
    end
    if (n == 200) begin
      checks++; errors++;
      $display("FAIL cmd_accept: got no cmd_ready within 200 cycles, required ready");
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic feed_pair(input logic [7:0] a, input logic [7:0] b, input int stall);
    int n;
    for (int i = 0; i < stall; i++) begin
      a_valid = 1'b1; b_valid = 1'b0;
      a_data = 8'($urandom); b_data = 8'($urandom);
      tick();
    end
    a_valid = 1'b1; b_valid = 1'b1; a_data = a; b_data = b;
    for (n = 0; n < 200; n++) begin
      @(negedge clock);
      if (a_ready) break;
    end
    if (n == 200) begin
      checks++; errors++;
      $display("FAIL operand_xfer: got no a_ready within 200 cycles, required ready");
    end
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    for (n = 0; n < 2000; n++) begin
      @(negedge clock);
      if (!busy) break;
    end
    if (n == 2000) begin
      checks++; errors++;
      $display("FAIL wait_idle: got busy for 2000 cycles, required idle");
    end
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    chk_en  = 1'b1;
    @(negedge clock);
    chk("rst busy", busy, 0);
    chk("rst cmd_ready", cmd_ready, 1);
    chk("rst err", err, 0);

    // PRELOAD from reset
    tick();
    send_cmd(2'd0, 0, 16'h1234);
    @(negedge clock);
    chk("pre d", tile_in_d, 16'h1234);
    chk("pre prop", tile_in_propagate, 1);
    chk("pre cmd_ready low", cmd_ready, 0);
    @(negedge clock);
    chk("pre d cleared", tile_in_d, 16'h0000);
    chk("pre cmd_ready back", cmd_ready, 1);

    // Reset in the middle of streaming
    tick();
    send_cmd(2'd1, 4, 16'h0);
    feed_pair(8'h11, 8'h22, 0);
    feed_pair(8'h33, 8'h44, 0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst2 busy", busy, 0);
    chk("rst2 a", tile_in_a, 0);
    chk("rst2 b", tile_in_b, 0);
    chk("rst2 d", tile_in_d, 0);
    chk("rst2 prop", tile_in_propagate, 0);
    chk("rst2 res_valid", res_valid, 0);
    chk("rst2 cmd_ready", cmd_ready, 1);

    // COMPUTE with a two-cycle b stall before the second pair
    tick();
    mac_sum = 0; xfers = 0;
    send_cmd(2'd1, 3, 16'h0);
    feed_pair(8'd2, 8'd3, 0);
    feed_pair(8'd4, 8'd5, 2);
    feed_pair(8'd1, 8'd7, 0);
    wait_idle();
    chk("stall xfers", xfers, 3);
    chk("stall mac", mac_sum, 33);

    // FLUSH with result backpressure
    tick();
    tile_out_c = 16'h0020; res_ready = 1'b0;
    send_cmd(2'd2, 0, 16'h0);
    for (n = 0; n < 50; n++) begin
      @(negedge clock);
      if (res_valid) break;
    end
    chk("flush latency", n, PE_LAT + 1);
    chk("flush prop", tile_in_propagate, 1);
    tile_out_c = 16'hbeef;
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clock);
      chk("flush hold data", res_data, 16'h0020);
      chk("flush hold valid", res_valid, 1);
      chk("flush hold cmd_ready", cmd_ready, 0);
    end
    tick();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    @(negedge clock);
    chk("flush done valid", res_valid, 0);
    chk("flush done cmd_ready", cmd_ready, 1);

    // Zero-length COMPUTE, then illegal opcode, then PRELOAD
    tick();
    ready_pulses = 0;
    a_valid = 1'b1; b_valid = 1'b1;
    send_cmd(2'd1, 0, 16'h0);
    @(negedge clock);
    chk("len0 busy", busy, 0);
    tick();
    send_cmd(2'd3, 0, 16'h0);
    @(negedge clock);
    chk("illegal err", err, 1);
    chk("illegal busy", busy, 0);
    tick();
    send_cmd(2'd0, 0, 16'h00aa);
    wait_idle();
    a_valid = 1'b0; b_valid = 1'b0;
    chk("err sticky", err, 1);
    chk("len0 no ready", ready_pulses, 0);

    // Back-to-back PRELOAD, COMPUTE 255 with continuous operands, FLUSH
    tick();
    xfers = 0; results = 0; first_x = -1; last_x = -1;
    res_ready = 1'b1;
    drv_mode = 1;
    send_cmd(2'd0, 0, 16'h0001);
    send_cmd(2'd1, 255, 16'h0);
    wait_idle();
    drv_mode = 0;
    a_valid = 1'b0; b_valid = 1'b0;
    tick();
    send_cmd(2'd2, 0, 16'h0);
    wait_idle();
    chk("b2b xfers", xfers, 255);
    chk("b2b contiguous", last_x - first_x + 1, 255);
    chk("b2b results", results, 1);

    // Randomized traffic, checked cycle by cycle against the model
    tick();
    drv_mode = 2;
    repeat (800) tick();
    drv_mode = 0;
    cmd_valid = 1'b0; reset_n = 1'b1; res_ready = 1'b1;
    a_valid = 1'b1; b_valid = 1'b1;
    wait_idle();
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
